// File: rtl/tile_arb_pkg.sv
//==============================================================================
// tile_arb_pkg : shared types and default widths for the tile RAM arbiter.
// Rev 1.0
//==============================================================================
`default_nettype none

package tile_arb_pkg;

  localparam int C_ADDR_W     = 16;
  localparam int C_DATA_W     = 16;
  localparam int C_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_PEND = 2'd1,
    RD_WAIT = 2'd2
  } arb_state_t;

  // One character cell as the renderer sees it.
  typedef struct packed {
    logic [7:0] attr;
    logic [7:0] char;
  } tile_cell_t;

  // Pointer width carries one extra bit so full and empty stay distinguishable.
  function automatic int fifo_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tile_arb_wfifo.sv
//==============================================================================
// tile_arb_wfifo : synchronous {addr,data} write FIFO, async active-low reset.
// Rev 1.0
//==============================================================================
`default_nettype none

module tile_arb_wfifo
  import tile_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int C_PTR_W = fifo_ptr_w(DEPTH);
  localparam int C_IDX_W = C_PTR_W - 1;
  localparam logic [C_PTR_W-1:0] C_PTR_ONE = 1;

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [C_PTR_W-1:0] r_wr_ptr;
  logic [C_PTR_W-1:0] r_rd_ptr;
  logic               w_do_push;
  logic               w_do_pop;

  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[C_IDX_W-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      end
    end
  end

  assign empty    = (r_wr_ptr == r_rd_ptr);
  assign full     = (r_wr_ptr[C_IDX_W] != r_rd_ptr[C_IDX_W]) &&
                    (r_wr_ptr[C_IDX_W-1:0] == r_rd_ptr[C_IDX_W-1:0]);
  assign pop_data = r_mem[r_rd_ptr[C_IDX_W-1:0]];

endmodule

`default_nettype wire

// File: rtl/tile_ram_arbiter.sv
//==============================================================================
// tile_ram_arbiter : renderer-priority arbiter for the single-port tile RAM.
// Optional stall statistic: define TILE_ARB_STALL_COUNT_EN.       Rev 1.0
//==============================================================================
`default_nettype none

module tile_ram_arbiter
  import tile_arb_pkg::*;
#(
  parameter int FIFO_DEPTH = C_FIFO_DEPTH,
  parameter int ADDR_W     = C_ADDR_W,
  parameter int DATA_W     = C_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ren_busy,
  input  logic [ADDR_W-1:0] ren_addr,
  output logic [DATA_W-1:0] ren_read,
  input  logic              cpu_wr_req,
  input  logic [ADDR_W-1:0] cpu_wr_addr,
  input  logic [DATA_W-1:0] cpu_wr_data,
  output logic              cpu_wr_ready,
  input  logic              cpu_rd_req,
  input  logic [ADDR_W-1:0] cpu_rd_addr,
  output logic              cpu_rd_ready,
  output logic              cpu_rd_valid,
  output logic [DATA_W-1:0] cpu_rd_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [15:0]       stall_count
);

  localparam int C_ENTRY_W = ADDR_W + DATA_W;

  arb_state_t          r_state;
  arb_state_t          w_state_next;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic [DATA_W-1:0]   r_rd_data;
  logic                r_rd_valid;

  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic                w_rd_accept;
  logic                w_rd_issue;
  logic [C_ENTRY_W-1:0] w_head;
  logic [ADDR_W-1:0]   w_head_addr;
  logic [DATA_W-1:0]   w_head_data;

  assign cpu_wr_ready = !w_full && (r_state != RD_PEND);
  assign cpu_rd_ready = (r_state == IDLE);
  assign w_push       = cpu_wr_req && cpu_wr_ready;
  assign w_rd_accept  = cpu_rd_req && cpu_rd_ready;

  // A pending read waits behind every queued write, so it only issues on an empty FIFO.
  assign w_pop      = !ren_busy && !w_empty && ((r_state == IDLE) || (r_state == RD_PEND));
  assign w_rd_issue = !ren_busy && w_empty && (r_state == RD_PEND);

  assign {w_head_addr, w_head_data} = w_head;

  tile_arb_wfifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (C_ENTRY_W)
  ) u_wfifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .push_data ({cpu_wr_addr, cpu_wr_data}),
    .pop       (w_pop),
    .pop_data  (w_head),
    .full      (w_full),
    .empty     (w_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    ram_addr     = ren_addr;
    ram_din      = '0;
    ram_we       = 1'b0;

    case (r_state)
      IDLE:    if (w_rd_accept) w_state_next = RD_PEND;
      RD_PEND: if (w_rd_issue)  w_state_next = RD_WAIT;
      RD_WAIT: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase

    if (w_pop) begin
      ram_addr = w_head_addr;
      ram_din  = w_head_data;
      ram_we   = 1'b1;
    end else if (w_rd_issue) begin
      ram_addr = r_rd_addr;
    end
  end

  // RAM data is already registered in RD_WAIT, so a renderer grab that cycle is harmless.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_addr  <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= (r_state == RD_WAIT);
      if (r_state == RD_WAIT) begin
        r_rd_data <= ram_dout;
      end
      if (w_rd_accept) begin
        r_rd_addr <= cpu_rd_addr;
      end
    end
  end

  assign cpu_rd_valid = r_rd_valid;
  assign cpu_rd_data  = r_rd_data;
  assign ren_read     = ram_dout;

`ifdef TILE_ARB_STALL_COUNT_EN
  logic [15:0] r_stall_count;
  logic        w_stalled;

  assign w_stalled = ren_busy && (!w_empty || (r_state == RD_PEND));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_count <= 16'd0;
    end else if (w_stalled && (r_stall_count != 16'hFFFF)) begin
      r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign stall_count = r_stall_count;
`else
  assign stall_count = 16'd0;
`endif

endmodule

`default_nettype wire
